mux_arb: RTL

- Packet-level round-robin arbiter and flow controller for the 2:1 router output mux.
- Watches the valid flags and flit-type fields of input ports 0 and 1, and drives the mux `sel`.
- Locks the output to one input from HEAD flit to TAIL flit.
- Gates every flit transfer on downstream credits: one credit per flit, returned by the downstream buffer.

---
 rtl/mux_arb.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mux_arb.sv
// mux_arb: packet-level round-robin arbiter for a 2:1 router output mux.
// Holds the output from HEAD to TAIL and gates every flit on downstream credits.
module mux_arb #(
   parameter int PORTW   = 5,
   parameter int CREDITS = 4,
   parameter int CNTW    = 3
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic             ivalid_0,
   input  logic [1:0]       itype_0,
   input  logic             ivalid_1,
   input  logic [1:0]       itype_1,
   input  logic             icredit,
   output logic [PORTW-1:0] sel,
   output logic             ogrant_0,
   output logic             ogrant_1,
   output logic             ovalid,
   output logic             obusy,
   output logic [CNTW-1:0]  ocredit,
   output logic             oerr
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam logic [1:0]      TYPE_NONE  = 2'd0;
   localparam logic [1:0]      TYPE_HEAD  = 2'd1;
   localparam logic [1:0]      TYPE_DATA  = 2'd2;
   localparam logic [1:0]      TYPE_TAIL  = 2'd3;
   localparam logic [CNTW-1:0] CREDIT_MAX = CNTW'(CREDITS);
   localparam logic [CNTW-1:0] CREDIT_ONE = CNTW'(1);

   state_t           state_q, state_d;
   logic             rrLast_q, rrLast_d;
   logic             headDone_q, headDone_d;
   logic [PORTW-1:0] sel_q, sel_d;
   logic [CNTW-1:0]  credit_q, credit_d;
   logic             err_q, err_d;

   logic             fire0, fire1, fire;
   logic [1:0]       fireType;
   logic             req0, req1;
   logic             stray0, stray1;

   always_comb begin
      state_d    = state_q;
      rrLast_d   = rrLast_q;
      headDone_d = headDone_q;
      sel_d      = sel_q;
      credit_d   = credit_q;
      err_d      = err_q;

      fire0    = (state_q == OWN0) && ivalid_0 && (itype_0 != TYPE_NONE) && (credit_q != '0);
      fire1    = (state_q == OWN1) && ivalid_1 && (itype_1 != TYPE_NONE) && (credit_q != '0);
      fire     = fire0 || fire1;
      fireType = fire1 ? itype_1 : itype_0;

      req0   = ivalid_0 && (itype_0 == TYPE_HEAD);
      req1   = ivalid_1 && (itype_1 == TYPE_HEAD);
      stray0 = ivalid_0 && ((itype_0 == TYPE_DATA) || (itype_0 == TYPE_TAIL));
      stray1 = ivalid_1 && ((itype_1 == TYPE_DATA) || (itype_1 == TYPE_TAIL));

      // On a tie the port that was not served last wins; rrLast starts at 1 so port 0 wins first.
      case (state_q)
         IDLE: begin
            if (stray0 || stray1) begin
               err_d = 1'b1;
            end
            if (req0 && (!req1 || rrLast_q)) begin
               state_d    = OWN0;
               sel_d      = '0;
               rrLast_d   = 1'b0;
               headDone_d = 1'b0;
            end else if (req1) begin
               state_d    = OWN1;
               sel_d      = PORTW'(1);
               rrLast_d   = 1'b1;
               headDone_d = 1'b0;
            end
         end
         default: begin
            if (fire) begin
               headDone_d = 1'b1;
               if ((fireType == TYPE_HEAD) && headDone_q) begin
                  err_d = 1'b1;
               end
               if (fireType == TYPE_TAIL) begin
                  state_d = IDLE;
               end
            end
         end
      endcase

      // A returned credit with the counter already full is a downstream protocol error.
      if (fire && !icredit) begin
         credit_d = credit_q - CREDIT_ONE;
      end else if (!fire && icredit) begin
         if (credit_q == CREDIT_MAX) begin
            err_d = 1'b1;
         end else begin
            credit_d = credit_q + CREDIT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         state_q    <= IDLE;
         rrLast_q   <= 1'b1;
         headDone_q <= 1'b0;
         sel_q      <= '0;
         credit_q   <= CREDIT_MAX;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rrLast_q   <= rrLast_d;
         headDone_q <= headDone_d;
         sel_q      <= sel_d;
         credit_q   <= credit_d;
         err_q      <= err_d;
      end
   end

   assign sel      = sel_q;
   assign ogrant_0 = fire0;
   assign ogrant_1 = fire1;
   assign ovalid   = fire;
   assign obusy    = (state_q != IDLE);
   assign ocredit  = credit_q;
   assign oerr     = err_q;

endmodule
